// File: rtl/instr_loader.sv
// Byte-serial program loader: packs 4 little-endian bytes per instruction word and writes them to instruction memory.
// Latency: 5 cycles per word with bytes streaming back-to-back (4 accept cycles + 1 write cycle).
// Backpressure: byte_ready drops in IDLE/WRITE/DONE; optional trailer checksum via LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_hold,
    output logic                  chk_err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, CHECK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

    localparam logic [ADDR_WIDTH:0]   WC_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   wc_q;
    logic [ADDR_WIDTH:0]   ww_q;
    logic [1:0]            bidx_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept;
    logic                  start_ok;
    logic                  last_word;

    assign accept    = byte_valid & byte_ready;
    assign start_ok  = start & ((state_q == IDLE) | (state_q == DONE));
    assign last_word = ((ww_q + WC_ONE) == wc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = (word_count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept && (bidx_q == 2'd3)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = COLLECT;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (accept) begin
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign cpu_hold = busy;
    assign mem_addr = addr_q;
    assign mem_data = data_q;

    // Datapath; a reset mid-word simply drops the partial word held in data_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_q   <= '0;
            ww_q   <= '0;
            bidx_q <= '0;
            data_q <= '0;
            addr_q <= '0;
        end else begin
            if (start_ok) begin
                wc_q   <= word_count;
                ww_q   <= '0;
                bidx_q <= '0;
                data_q <= '0;
                addr_q <= '0;
            end
            if ((state_q == COLLECT) && accept) begin
                data_q[{bidx_q, 3'b000} +: 8] <= byte_in;
                bidx_q                        <= bidx_q + 2'd1;
            end
            if (state_q == WRITE) begin
                addr_q <= addr_q + ADDR_ONE;
                ww_q   <= ww_q + WC_ONE;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       chk_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            chk_err_q <= 1'b0;
        end else begin
            if (start_ok) begin
                sum_q     <= '0;
                chk_err_q <= 1'b0;
            end
            if ((state_q == COLLECT) && accept) begin
                sum_q <= sum_q + byte_in;
            end
            if ((state_q == CHECK) && accept) begin
                chk_err_q <= (byte_in != sum_q);
            end
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: table-driven loads plus hand-written timing, reset, start-ignore and fill sequences.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        cpu_hold;
    logic        chk_err;

    instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tmo_cnt = 0;
    int hold_bad = 0;
    logic busy_seen = 1'b0;
    logic [9:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  sum;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
        if (busy) busy_seen <= 1'b1;
        if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
    end

    typedef struct {
        int          wc;
        int          gap;
        logic [7:0]  b   [12];
        logic [31:0] exp [3];
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [10:0] wc);
        @(negedge clk);
        start      = 1'b1;
        word_count = wc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_in    = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) tmo_cnt++;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        busy_seen = 1'b0;
        tmo_cnt   = 0;
    endtask

    task automatic run_vec(input int i);
        clear_mon();
        do_start(11'(vecs[i].wc));
        sum = 8'h00;
        if (vecs[i].wc == 0) begin
            check($sformatf("v%0d_done_next", i), done, 1);
            check($sformatf("v%0d_busy_now", i), busy, 0);
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_busy_never", i), busy_seen, 0);
            check($sformatf("v%0d_nwrites", i), wr_addr.size(), 0);
        end else begin
            for (int w = 0; w < vecs[i].wc; w++)
                for (int k = 0; k < 4; k++) begin
                    send_byte(vecs[i].b[w*4+k], vecs[i].gap);
                    sum = sum + vecs[i].b[w*4+k];
                end
            byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            send_byte(sum, 0);
            byte_valid = 1'b0;
`endif
            wait_done();
            check($sformatf("v%0d_timeouts", i), tmo_cnt, 0);
            check($sformatf("v%0d_nwrites", i), wr_addr.size(), vecs[i].wc);
            for (int w = 0; w < vecs[i].wc && w < wr_addr.size(); w++) begin
                check($sformatf("v%0d_addr%0d", i, w), wr_addr[w], w);
                check($sformatf("v%0d_data%0d", i, w), wr_data[w], vecs[i].exp[w]);
            end
            check($sformatf("v%0d_chk_err", i), chk_err, 0);
        end
    endtask

    initial begin
        logic [7:0] bb [4];
        int bad;
        rst = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;

        vecs[0] = '{1, 0, '{8'h13, 8'h00, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    '{32'h00500013, 32'h0, 32'h0}};
        vecs[1] = '{3, 1, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA, 8'hBB, 8'hCC, 8'hDD},
                    '{32'h44332211, 32'h88776655, 32'hDDCCBBAA}};
        vecs[2] = '{2, 0, '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00},
                    '{32'hDEADBEEF, 32'h12345678, 32'h0}};
        vecs[3] = '{0, 0, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    '{32'h0, 32'h0, 32'h0}};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", {byte_ready, mem_we, busy, done, cpu_hold, chk_err}, 6'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        rst = 1'b0;

        // Back-to-back single word: write must land in the 5th cycle after start
        clear_mon();
        bb = '{8'h13, 8'h00, 8'h50, 8'h00};
        @(negedge clk);
        start = 1'b1; word_count = 11'd1; byte_valid = 1'b1; byte_in = bb[0];
        bad = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start   = 1'b0;
            byte_in = bb[c-1];
            if (mem_we !== 1'b0) bad++;
        end
        check("t5_no_early_we", bad, 0);
        @(negedge clk);
        byte_valid = 1'b0;
        check("t5_we", mem_we, 1);
        check("t5_addr", mem_addr, 0);
        check("t5_data", mem_data, 32'h00500013);
        check("t5_no_ready_in_write", byte_ready, 0);
`ifdef LOADER_CHECKSUM_EN
        @(negedge clk);
        send_byte(8'h63, 0);
        byte_valid = 1'b0;
`else
        @(negedge clk);
`endif
        check("t5_done", done, 1);
        check("t5_one_write", wr_addr.size(), 1);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset after two bytes of the first word
        clear_mon();
        do_start(11'd2);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {byte_ready, mem_we, busy, done, cpu_hold, chk_err}, 6'b0);
        check("mid_rst_data", mem_data, 0);
        check("mid_rst_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_rst_no_write", wr_addr.size(), 0);
        run_vec(2);

        // start pulsed mid-load must not restart or resize the load
        clear_mon();
        do_start(11'd2);
        send_byte(8'h01, 0);
        byte_valid = 1'b0;
        start = 1'b1; word_count = 11'd5;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
        byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h24, 0);
        byte_valid = 1'b0;
`endif
        wait_done();
        check("ign_nwrites", wr_addr.size(), 2);
        if (wr_data.size() == 2) begin
            check("ign_data0", wr_data[0], 32'h04030201);
            check("ign_data1", wr_data[1], 32'h08070605);
            check("ign_addr1", wr_addr[1], 1);
        end

`ifdef LOADER_CHECKSUM_EN
        do_start(11'd1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h0A, 0);
        byte_valid = 1'b0;
        wait_done();
        check("cks_good", chk_err, 0);
        do_start(11'd1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        send_byte(8'h0B, 0);
        byte_valid = 1'b0;
        wait_done();
        check("cks_bad", chk_err, 1);
        check("cks_bad_done", done, 1);
`endif

        // Full address space
        clear_mon();
        do_start(11'd1024);
        sum = 8'h00;
        for (int w = 0; w < 1024; w++) begin
            send_byte(8'(w), 0);
            send_byte(8'(w >> 8), 0);
            send_byte(8'h5A, 0);
            send_byte(8'hA5, 0);
            sum = sum + 8'(w) + 8'(w >> 8) + 8'h5A + 8'hA5;
        end
        byte_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        send_byte(sum, 0);
        byte_valid = 1'b0;
`endif
        wait_done();
        check("fill_nwrites", wr_addr.size(), 1024);
        bad = 0;
        for (int w = 0; w < wr_addr.size(); w++) begin
            if (wr_addr[w] !== 10'(w)) bad++;
            if (wr_data[w] !== {8'hA5, 8'h5A, 8'(w >> 8), 8'(w)}) bad++;
        end
        check("fill_contents", bad, 0);
        check("fill_addr_wrap", mem_addr, 0);
        check("fill_timeouts", tmo_cnt, 0);
        check("cpu_hold_eq_busy", hold_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
